regfile_wb_arbiter: RTL and testbench

//  Write-back initiator for the 32x32 register file, which has one write port (wreg/wdata/RegWrite).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file widths and the write-back request type used by the
// write-back arbiter and its LSU FIFO.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests with occupancy count. With
// WB_BYPASS_EN defined it also exports its live entries in age order (0 = head).
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_req_t                      push_data,
  input  logic                         pop,
  output wb_req_t                      head,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef WB_BYPASS_EN
  ,
  output logic [DEPTH-1:0]             entry_valid,
  output wb_req_t [DEPTH-1:0]          entries
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // NOTE: the storage array has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

`ifdef WB_BYPASS_EN
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries[k]     = mem[rd_ptr + PTR_W'(k)];
      entry_valid[k] = CNT_W'(k) < count;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (priority) and buffered LSU results onto the single register-file
// write port, with LSU anti-starvation. Optional forwarding lookup: WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_STALL = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_ADDR_W-1:0]        alu_waddr,
  input  logic [REG_DATA_W-1:0]        alu_wdata,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [REG_ADDR_W-1:0]        lsu_waddr,
  input  logic [REG_DATA_W-1:0]        lsu_wdata,
  output logic                         wb_wen,
  output logic [REG_ADDR_W-1:0]        wb_waddr,
  output logic [REG_DATA_W-1:0]        wb_wdata,
`ifdef WB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0]        byp_raddr_a,
  output logic                         byp_hit_a,
  output logic [REG_DATA_W-1:0]        byp_data_a,
  input  logic [REG_ADDR_W-1:0]        byp_raddr_b,
  output logic                         byp_hit_b,
  output logic [REG_DATA_W-1:0]        byp_data_b,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int STALL_W = $clog2(MAX_STALL+1);
  localparam logic [CNT_W-1:0]   FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);

  logic               starve;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_inc;
  logic               fifo_empty;
  logic               alu_issue;
  logic               lsu_push;
  logic               pop;
  wb_req_t            head;

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0]    entry_valid;
  wb_req_t [DEPTH-1:0] entries;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lsu_push),
    .push_data ('{addr: lsu_waddr, data: lsu_wdata}),
    .pop       (pop),
    .head      (head),
    .count     (pending_cnt)
`ifdef WB_BYPASS_EN
    ,
    .entry_valid (entry_valid),
    .entries     (entries)
`endif
  );

  // Writes to $0 are handshaken but never reach the FIFO or the port.
  assign alu_ready  = !starve;
  assign lsu_ready  = pending_cnt < FULL_CNT;
  assign alu_issue  = alu_valid && alu_ready && (alu_waddr != REG_ZERO);
  assign lsu_push   = lsu_valid && lsu_ready && (lsu_waddr != REG_ZERO);
  assign fifo_empty = (pending_cnt == '0);
  assign pop        = !fifo_empty && (starve || !alu_issue);
  assign stall_inc  = stall_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wen    <= 1'b0;
      wb_waddr  <= REG_ZERO;
      wb_wdata  <= '0;
      stall_cnt <= '0;
      starve    <= 1'b0;
    end else begin
      wb_wen <= pop || alu_issue;
      if (pop) begin
        wb_waddr <= head.addr;
        wb_wdata <= head.data;
      end else if (alu_issue) begin
        wb_waddr <= alu_waddr;
        wb_wdata <= alu_wdata;
      end
      // The head's wait is counted only while it sits unserved.
      stall_cnt <= (fifo_empty || pop) ? '0 : stall_inc;
      if (pop)                                           starve <= 1'b0;
      else if (!fifo_empty && stall_inc == STALL_LIMIT)  starve <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Youngest FIFO entry wins among queued writes; the wb stage overrides all.
  function automatic logic [REG_DATA_W:0] lookup(
    input logic [REG_ADDR_W-1:0] raddr,
    input logic                  st_wen,
    input logic [REG_ADDR_W-1:0] st_waddr,
    input logic [REG_DATA_W-1:0] st_wdata,
    input logic [DEPTH-1:0]      ent_valid,
    input wb_req_t [DEPTH-1:0]   ent
  );
    logic [REG_DATA_W:0] res;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && ent[k].addr == raddr) res = {1'b1, ent[k].data};
    end
    if (st_wen && st_waddr == raddr) res = {1'b1, st_wdata};
    if (raddr == REG_ZERO)           res = '0;
    return res;
  endfunction

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    {byp_hit_a, byp_data_a} = lookup(byp_raddr_a, wb_wen, wb_waddr, wb_wdata, entry_valid, entries);
    {byp_hit_b, byp_data_b} = lookup(byp_raddr_b, wb_wen, wb_waddr, wb_wdata, entry_valid, entries);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic against a queue-based reference model. Bypass checks under WB_BYPASS_EN.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MAX_STALL = 8;
  localparam int CNT_W     = $clog2(DEPTH+1);

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_waddr, lsu_waddr, wb_waddr;
  logic [31:0] alu_wdata, lsu_wdata, wb_wdata;
  logic        wb_wen;
  logic [CNT_W-1:0] pending_cnt;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_raddr_a, byp_raddr_b;
  logic        byp_hit_a, byp_hit_b;
  logic [31:0] byp_data_a, byp_data_b;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
`ifdef WB_BYPASS_EN
    .byp_raddr_a(byp_raddr_a), .byp_hit_a(byp_hit_a), .byp_data_a(byp_data_a),
    .byp_raddr_b(byp_raddr_b), .byp_hit_b(byp_hit_b), .byp_data_b(byp_data_b),
`endif
    .pending_cnt(pending_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of pending LSU writes, the head's wait time and
  // the forced-service flag, plus the expected write-port contents.
  wb_req_t     q[$];
  int          m_wait;
  bit          m_force;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          alu_acc, lsu_acc;
  logic        obs_alu_ready;

  function automatic logic [32:0] m_lookup(input logic [4:0] ra);
    if (ra == 5'd0) return '0;
    if (m_wen && m_waddr == ra) return {1'b1, m_wdata};
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].addr == ra) return {1'b1, q[i].data};
    return '0;
  endfunction

  function automatic bit lsu_pending(input logic [4:0] ra);
    foreach (q[i]) if (q[i].addr == ra) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_waddr = 5'd0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_waddr = 5'd0; lsu_wdata = '0;
  endtask

  // One clock: compare readies (and bypass) against the model, advance the
  // model by the arbitration rules, then compare the write port after the edge.
  task automatic cycle();
    bit exp_alu_ready, exp_lsu_ready, alu_iss, push, nonempty, do_pop;
    logic [32:0] exp_byp;
    #1;
    obs_alu_ready = alu_ready;
    exp_alu_ready = !m_force;
    exp_lsu_ready = q.size() < DEPTH;
    if (!rst) begin
      tests++;
      if (alu_ready !== exp_alu_ready) begin
        fails++; $display("FAIL alu_ready: got %b expected %b at %0t", alu_ready, exp_alu_ready, $time);
      end
      tests++;
      if (lsu_ready !== exp_lsu_ready) begin
        fails++; $display("FAIL lsu_ready: got %b expected %b at %0t", lsu_ready, exp_lsu_ready, $time);
      end
`ifdef WB_BYPASS_EN
      exp_byp = m_lookup(byp_raddr_a);
      tests++;
      if ({byp_hit_a, byp_data_a} !== exp_byp) begin
        fails++; $display("FAIL bypass_a: got %b/%h expected %b/%h at %0t", byp_hit_a, byp_data_a, exp_byp[32], exp_byp[31:0], $time);
      end
      exp_byp = m_lookup(byp_raddr_b);
      tests++;
      if ({byp_hit_b, byp_data_b} !== exp_byp) begin
        fails++; $display("FAIL bypass_b: got %b/%h expected %b/%h at %0t", byp_hit_b, byp_data_b, exp_byp[32], exp_byp[31:0], $time);
      end
`endif
    end

    alu_acc  = !rst && alu_valid && exp_alu_ready;
    lsu_acc  = !rst && lsu_valid && exp_lsu_ready;
    alu_iss  = alu_acc && alu_waddr != 5'd0;
    push     = lsu_acc && lsu_waddr != 5'd0;
    nonempty = q.size() != 0;
    if (alu_iss)
      a_no_waw: assert (!lsu_pending(alu_waddr))
        else $error("ALU write to $%0d while an LSU write to it is outstanding", alu_waddr);

    if (rst) begin
      q.delete(); m_wait = 0; m_force = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      if (m_force && nonempty)  do_pop = 1'b1;
      else if (alu_iss)         do_pop = 1'b0;
      else                      do_pop = nonempty;
      if (do_pop) begin
        m_wen = 1'b1; m_waddr = q[0].addr; m_wdata = q[0].data; void'(q.pop_front());
      end else if (alu_iss) begin
        m_wen = 1'b1; m_waddr = alu_waddr; m_wdata = alu_wdata;
      end else begin
        m_wen = 1'b0;
      end
      if (!nonempty || do_pop) m_wait = 0; else m_wait++;
      if (do_pop)                    m_force = 1'b0;
      else if (m_wait == MAX_STALL)  m_force = 1'b1;
      if (push) q.push_back('{addr: lsu_waddr, data: lsu_wdata});
    end

    @(posedge clk);
    #1;
    tests++;
    if (wb_wen !== m_wen) begin
      fails++; $display("FAIL wb_wen: got %b expected %b at %0t", wb_wen, m_wen, $time);
    end
    tests++;
    if (wb_waddr !== m_waddr || wb_wdata !== m_wdata) begin
      fails++; $display("FAIL wb_addr_data: got %0d/%h expected %0d/%h at %0t", wb_waddr, wb_wdata, m_waddr, m_wdata, $time);
    end
    tests++;
    if (pending_cnt !== CNT_W'(q.size())) begin
      fails++; $display("FAIL pending_cnt: got %0d expected %0d at %0t", pending_cnt, q.size(), $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs(); cycle(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (wb_wen !== 1'b0 || wb_waddr !== 5'd0 || wb_wdata !== 32'd0 || pending_cnt !== '0) begin
      fails++; $display("FAIL reset_state: got wen=%b addr=%0d data=%h cnt=%0d expected 0/0/0/0", wb_wen, wb_waddr, wb_wdata, pending_cnt);
    end
    tests++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got alu=%b lsu=%b expected 1/1", alu_ready, lsu_ready);
    end
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hA5A5_0001;
    cycle();
    tests++;
    if (wb_wen !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'hA5A5_0001 || obs_alu_ready !== 1'b1) begin
      fails++; $display("FAIL alu_only: got wen=%b addr=%0d data=%h ready=%b expected 1/5/a5a50001/1", wb_wen, wb_waddr, wb_wdata, obs_alu_ready);
    end
    idle_inputs();
    cycle();
    tests++;
    if (wb_wen !== 1'b0 || wb_waddr !== 5'd5 || wb_wdata !== 32'hA5A5_0001) begin
      fails++; $display("FAIL alu_idle_hold: got wen=%b addr=%0d data=%h expected 0/5/a5a50001", wb_wen, wb_waddr, wb_wdata);
    end
  endtask

  task automatic test_lsu_only();
    logic [4:0]  exp_addr [4];
    logic        exp_wen  [4];
    int          exp_cnt  [4];
    exp_wen = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_addr = '{5'd5, 5'd7, 5'd8, 5'd8};
    exp_cnt = '{1, 1, 0, 0};
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h1234; end
      if (c == 1) begin lsu_valid = 1'b1; lsu_waddr = 5'd8; lsu_wdata = 32'h5678; end
      cycle();
      tests++;
      if (wb_wen !== exp_wen[c] || wb_waddr !== exp_addr[c] || pending_cnt !== CNT_W'(exp_cnt[c])) begin
        fails++; $display("FAIL lsu_only[%0d]: got wen=%b addr=%0d cnt=%0d expected %b/%0d/%0d", c, wb_wen, wb_waddr, pending_cnt, exp_wen[c], exp_addr[c], exp_cnt[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    wb_req_t sent[$];
    wb_req_t seen[$];
    int  idx = 0;
    int  budget = 0;
    bit  saw_full = 0;
    logic [31:0] d;
    do_reset();
    d = $urandom;
    while (seen.size() < 5 && budget < 120) begin
      alu_valid = 1'b1; alu_waddr = 5'(1 + budget % 15); alu_wdata = $urandom;
      lsu_valid = idx < 5; lsu_waddr = 5'(16 + idx); lsu_wdata = d;
      if (lsu_valid && !lsu_ready && pending_cnt == CNT_W'(DEPTH)) saw_full = 1'b1;
      cycle();
      if (lsu_acc) begin sent.push_back('{addr: lsu_waddr, data: lsu_wdata}); idx++; d = $urandom; end
      if (wb_wen && wb_waddr >= 5'd16) seen.push_back('{addr: wb_waddr, data: wb_wdata});
      budget++;
    end
    idle_inputs();
    tests++;
    if (!saw_full) begin
      fails++; $display("FAIL full_backpressure: lsu_ready never 0 at pending_cnt=%0d", DEPTH);
    end
    tests++;
    if (seen.size() != 5 || seen != sent) begin
      fails++; $display("FAIL lsu_order: got %0d of 5 writes in order expected all 5 (budget %0d)", seen.size(), budget);
    end
  endtask

  task automatic test_starvation();
    int low_cnt = 0;
    int low_idx = -1;
    int lsu_idx = -1;
    do_reset();
    for (int c = 0; c < MAX_STALL + 6; c++) begin
      alu_valid = 1'b1; alu_waddr = 5'(1 + c % 15); alu_wdata = 32'(c);
      lsu_valid = (c == 0); lsu_waddr = 5'd20; lsu_wdata = 32'hCAFE_0020;
      cycle();
      if (!obs_alu_ready) begin low_cnt++; low_idx = c; end
      if (wb_wen && wb_waddr == 5'd20) lsu_idx = c;
    end
    idle_inputs();
    tests++;
    if (low_cnt != 1 || low_idx != MAX_STALL + 1) begin
      fails++; $display("FAIL starve_window: got %0d low cycles at %0d expected 1 at %0d", low_cnt, low_idx, MAX_STALL + 1);
    end
    tests++;
    if (lsu_idx != MAX_STALL + 1) begin
      fails++; $display("FAIL starve_issue: got LSU write in cycle %0d expected %0d", lsu_idx, MAX_STALL + 1);
    end
  endtask

  task automatic test_zero_and_reset();
    bit leaked = 0;
    do_reset();
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hDEAD;
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'hBEEF;
    cycle();
    tests++;
    if (wb_wen !== 1'b0 || pending_cnt !== '0) begin
      fails++; $display("FAIL zero_reg: got wen=%b cnt=%0d expected 0/0", wb_wen, pending_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_waddr = 5'(1 + c); alu_wdata = $urandom;
      lsu_valid = 1'b1; lsu_waddr = 5'(24 + c); lsu_wdata = $urandom;
      cycle();
    end
    tests++;
    if (pending_cnt !== CNT_W'(3)) begin
      fails++; $display("FAIL queued_three: got cnt=%0d expected 3", pending_cnt);
    end
    rst = 1'b1; idle_inputs(); cycle(); rst = 1'b0;
    tests++;
    if (pending_cnt !== '0 || wb_wen !== 1'b0) begin
      fails++; $display("FAIL mid_reset: got cnt=%0d wen=%b expected 0/0", pending_cnt, wb_wen);
    end
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (wb_wen) leaked = 1'b1;
    end
    tests++;
    if (leaked) begin
      fails++; $display("FAIL reset_discard: got a write after reset expected none");
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    int budget = 0;
    bit in_wb = 0;
    do_reset();
    byp_raddr_a = 5'd9; byp_raddr_b = 5'd0;
    alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h1;
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'hBEEF;
    cycle();
    lsu_valid = 1'b0;
    tests++;
    if (byp_hit_a !== 1'b1 || byp_data_a !== 32'hBEEF || byp_hit_b !== 1'b0 || byp_data_b !== 32'd0) begin
      fails++; $display("FAIL bypass_queued: got a=%b/%h b=%b/%h expected 1/beef 0/0", byp_hit_a, byp_data_a, byp_hit_b, byp_data_b);
    end
    while (!in_wb && budget < 30) begin
      alu_waddr = 5'(1 + budget % 8); alu_wdata = $urandom;
      cycle();
      in_wb = wb_wen && wb_waddr == 5'd9;
      budget++;
    end
    tests++;
    if (!in_wb || byp_hit_a !== 1'b1 || byp_data_a !== 32'hBEEF) begin
      fails++; $display("FAIL bypass_wb_stage: got in_wb=%b hit=%b data=%h expected 1/1/beef", in_wb, byp_hit_a, byp_data_a);
    end
    cycle();
    tests++;
    if (byp_hit_a !== 1'b0 || byp_data_a !== 32'd0) begin
      fails++; $display("FAIL bypass_drop: got hit=%b data=%h expected 0/0", byp_hit_a, byp_data_a);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      if (!(alu_valid && !alu_acc)) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_waddr = 5'($urandom_range(0, 15));
        alu_wdata = $urandom;
      end
      if (!(lsu_valid && !lsu_acc)) begin
        lsu_valid = ($urandom_range(0, 1) != 0);
        lsu_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
        lsu_wdata = $urandom;
      end
`ifdef WB_BYPASS_EN
      byp_raddr_a = 5'($urandom_range(0, 31));
      byp_raddr_b = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
`endif
      rst = (c == 300);
      cycle();
      if (rst) begin idle_inputs(); alu_acc = 0; lsu_acc = 0; end
    end
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3 * DEPTH; c++) cycle();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    m_wait = 0; m_force = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
`ifdef WB_BYPASS_EN
    byp_raddr_a = '0; byp_raddr_b = '0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_alu_only();
    test_lsu_only();
    test_backpressure();
    test_starvation();
    test_zero_and_reset();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
